// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//
// Pixel-rate video timing and test-pattern source. A horizontal/vertical
// counter pair walks the full raster (active + porches + sync). Each enabled
// cycle, the current (h_cnt, v_cnt) position is decoded into sync, active,
// coordinate and pixel-colour values, and those values are registered. Every
// output therefore lags the counters by exactly one enabled cycle, and all
// outputs stay mutually aligned.
//
// The blue-channel TMDS encoder takes hsync/vsync as its c0/c1. The red and
// green encoders tie c0=c1=0.
//
// Ports
//   clk          pixel clock (single clock domain)
//   rst          synchronous active-high reset; takes priority over ce
//   ce           pixel enable; while low, all state and outputs hold
//   pattern_sel  00 colour bars, 01 solid, 10 grey ramp, 11 checkerboard
//   solid_rgb    {R,G,B} colour used by the solid pattern
//   hsync        horizontal sync, asserted level = HSYNC_POL
//   vsync        vertical sync, asserted level = VSYNC_POL (line aligned)
//   video_active high on visible pixels
//   red/green/blue  pixel colour, forced to 0 outside the visible area
//   x, y         visible pixel column/line, 0 outside the visible area
//   frame_start  high for the output cycle carrying pixel (0,0)
// -----------------------------------------------------------------------------
module video_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        video_active,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start
);

  // ---------------------------------------------------------------------------
  // Derived raster constants. The totals may reach 4096, and a sync window may
  // end exactly at 4096. The region comparisons therefore run on 13 bits, so
  // that a boundary of 4096 does not wrap to 0.
  // ---------------------------------------------------------------------------
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [12:0] H_ACT_END  = 13'(H_ACTIVE);
  localparam logic [12:0] H_SYNC_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SYNC_END = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT_END  = 13'(V_ACTIVE);
  localparam logic [12:0] V_SYNC_BEG = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_SYNC_END = 13'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  // Bar width is H_ACTIVE/8. It is clamped to 1 so that a very narrow raster
  // still gets a well-defined bar counter.
  localparam int unsigned BAR_W    = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1;
  localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);
  localparam logic [2:0]  BAR_MAX  = 3'd7;

  // Pattern encodings on pattern_sel.
  localparam logic [1:0] PAT_BARS  = 2'b00;
  localparam logic [1:0] PAT_SOLID = 2'b01;
  localparam logic [1:0] PAT_GREY  = 2'b10;
  localparam logic [1:0] PAT_CHECK = 2'b11;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [11:0] h_cnt_q,   h_cnt_d;
  logic [11:0] v_cnt_q,   v_cnt_d;
  logic [11:0] bar_cnt_q, bar_cnt_d;   // position inside the current bar
  logic [2:0]  bar_idx_q, bar_idx_d;   // bar index that belongs to h_cnt_q
  logic [1:0]  pat_q,     pat_d;       // pattern latched at the start of a frame
  logic [23:0] solid_q,   solid_d;

  // Registered outputs.
  logic        hsync_q,  hsync_d;
  logic        vsync_q,  vsync_d;
  logic        active_q, active_d;
  logic        fstart_q, fstart_d;
  logic [23:0] rgb_q,    rgb_d;
  logic [11:0] x_q,      x_d;
  logic [11:0] y_q,      y_d;

  // ---------------------------------------------------------------------------
  // Colour-bar palette.
  // ---------------------------------------------------------------------------
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    c = 24'h000000;
    case (idx)
      3'd0: c = 24'hFFFFFF;   // white
      3'd1: c = 24'hFFFF00;   // yellow
      3'd2: c = 24'h00FFFF;   // cyan
      3'd3: c = 24'h00FF00;   // green
      3'd4: c = 24'hFF00FF;   // magenta
      3'd5: c = 24'hFF0000;   // red
      3'd6: c = 24'h0000FF;   // blue
      default: c = 24'h000000; // black
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Raster counters and bar tracking
  // ---------------------------------------------------------------------------
  logic h_wrap;
  logic v_wrap;

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first. Without one, any path that skips the assignment infers a latch.
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;

    h_wrap = (h_cnt_q == H_LAST);
    v_wrap = (v_cnt_q == V_LAST);

    if (h_wrap) begin
      h_cnt_d = 12'd0;
      v_cnt_d = v_wrap ? 12'd0 : v_cnt_q + 12'd1;
    end else begin
      h_cnt_d = h_cnt_q + 12'd1;
    end

    // The bar index advances by counting pixels, not by dividing h_cnt. It
    // saturates at the last bar, so that bar absorbs any remainder of
    // H_ACTIVE/8. The counter realigns at the start of every line.
    if (h_wrap) begin
      bar_cnt_d = 12'd0;
      bar_idx_d = 3'd0;
    end else if (bar_cnt_q == BAR_LAST) begin
      bar_cnt_d = 12'd0;
      bar_idx_d = (bar_idx_q == BAR_MAX) ? BAR_MAX : bar_idx_q + 3'd1;
    end else begin
      bar_cnt_d = bar_cnt_q + 12'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Region and pattern decode of the current counter position
  // ---------------------------------------------------------------------------
  logic [12:0] h_ext;
  logic [12:0] v_ext;
  logic        at_origin;
  logic [1:0]  pat_eff;
  logic [23:0] solid_eff;
  logic        in_active;
  logic        in_hsync;
  logic        in_vsync;
  logic [23:0] pix_rgb;

  always_comb begin
    h_ext = {1'b0, h_cnt_q};
    v_ext = {1'b0, v_cnt_q};

    at_origin = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);

    // The pattern controls are sampled only at pixel (0,0), and that first
    // pixel already uses the new selection. A change made mid-frame is
    // therefore deferred to the next frame, and a frame never tears.
    pat_eff   = at_origin ? pattern_sel : pat_q;
    solid_eff = at_origin ? solid_rgb   : solid_q;
    pat_d     = pat_eff;
    solid_d   = solid_eff;

    in_active = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    in_hsync  = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
    // v_cnt only moves on a line wrap, so vsync is line-aligned.
    in_vsync  = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);

    pix_rgb = 24'h000000;
    case (pat_eff)
      PAT_BARS:  pix_rgb = bar_colour(bar_idx_q);
      PAT_SOLID: pix_rgb = solid_eff;
      PAT_GREY:  pix_rgb = {3{h_cnt_q[7:0]}};
      PAT_CHECK: pix_rgb = (h_cnt_q[3] ^ v_cnt_q[3]) ? 24'hFFFFFF : 24'h000000;
      default:   pix_rgb = 24'h000000;
    endcase

    hsync_d  = in_hsync ? HSYNC_POL : ~HSYNC_POL;
    vsync_d  = in_vsync ? VSYNC_POL : ~VSYNC_POL;
    active_d = in_active;
    fstart_d = at_origin;
    rgb_d    = in_active ? pix_rgb : 24'h000000;
    x_d      = in_active ? h_cnt_q : 12'd0;
    y_d      = in_active ? v_cnt_q : 12'd0;
  end

  // ---------------------------------------------------------------------------
  // Registers. Reset wins over ce. While ce is low, nothing is loaded, so
  // every output, frame_start included, keeps its last value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples the pre-edge values and evaluation order cannot
    // change the result.
    if (rst) begin
      h_cnt_q   <= 12'd0;
      v_cnt_q   <= 12'd0;
      bar_cnt_q <= 12'd0;
      bar_idx_q <= 3'd0;
      pat_q     <= PAT_BARS;
      solid_q   <= 24'h000000;
      hsync_q   <= ~HSYNC_POL;
      vsync_q   <= ~VSYNC_POL;
      active_q  <= 1'b0;
      fstart_q  <= 1'b0;
      rgb_q     <= 24'h000000;
      x_q       <= 12'd0;
      y_q       <= 12'd0;
    end else if (ce) begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      pat_q     <= pat_d;
      solid_q   <= solid_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      active_q  <= active_d;
      fstart_q  <= fstart_d;
      rgb_q     <= rgb_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign video_active = active_q;
  assign frame_start  = fstart_q;
  assign red          = rgb_q[23:16];
  assign green        = rgb_q[15:8];
  assign blue         = rgb_q[7:0];
  assign x            = x_q;
  assign y            = y_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//
// Self-checking bench for video_timing_gen on a small raster:
//   H 16/2/3/3 (H_TOTAL 24) and V 4/1/1/2 (V_TOTAL 8).
// A second instance uses H_ACTIVE=18 (H_TOTAL 26) for the bar-remainder case.
// Both instances share the stimulus. A behavioural model computes each pixel
// directly from its raster position.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

  localparam int HA0 = 16;
  localparam int HA1 = 18;
  localparam int HFP = 2;
  localparam int HSY = 3;
  localparam int HBP = 3;
  localparam int VA  = 4;
  localparam int VFP = 1;
  localparam int VSY = 1;
  localparam int VBP = 2;
  localparam int HT0 = HA0 + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        act;
    logic        fs;
    logic [23:0] rgb;
    logic [11:0] x;
    logic [11:0] y;
  } px_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_rgb;

  logic        hs0, vs0, act0, fs0;
  logic [7:0]  r0, g0, b0;
  logic [11:0] x0, y0;
  logic        hs1, vs1, act1, fs1;
  logic [7:0]  r1, g1, b1;
  logic [11:0] x1, y1;

  px_t got0, got1;
  assign got0 = {hs0, vs0, act0, fs0, r0, g0, b0, x0, y0};
  assign got1 = {hs1, vs1, act1, fs1, r1, g1, b1, x1, y1};

  video_timing_gen #(
    .H_ACTIVE(HA0), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA),  .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .hsync(hs0), .vsync(vs0), .video_active(act0),
    .red(r0), .green(g0), .blue(b0), .x(x0), .y(y0), .frame_start(fs0)
  );

  video_timing_gen #(
    .H_ACTIVE(HA1), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA),  .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_w18 (
    .clk(clk), .rst(rst), .ce(ce), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .hsync(hs1), .vsync(vs1), .video_active(act1),
    .red(r1), .green(g1), .blue(b1), .x(x1), .y(y1), .frame_start(fs1)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input px_t g, input px_t e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s: got hs=%0b vs=%0b act=%0b fs=%0b rgb=%06h x=%0d y=%0d, required hs=%0b vs=%0b act=%0b fs=%0b rgb=%06h x=%0d y=%0d",
               name, g.hs, g.vs, g.act, g.fs, g.rgb, g.x, g.y,
               e.hs, e.vs, e.act, e.fs, e.rgb, e.x, e.y);
    end
  endtask

  task automatic check_int(input string name, input int g, input int e);
    checks++;
    if (g != e) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, g, e);
    end
  endtask

  function automatic px_t mk(input logic hs, input logic vs, input logic act,
                             input logic fs, input logic [23:0] rgb,
                             input int xx, input int yy);
    px_t p;
    p.hs = hs; p.vs = vs; p.act = act; p.fs = fs; p.rgb = rgb;
    p.x = 12'(xx); p.y = 12'(yy);
    return p;
  endfunction

  function automatic px_t reset_px();
    return mk(1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 0, 0);
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: the pixel at raster position (h, v), from the raster rules
  // ---------------------------------------------------------------------------
  function automatic logic [23:0] bar_rgb(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic px_t model_px(input int ha, input int h, input int v,
                                   input logic [1:0] pat, input logic [23:0] solid);
    px_t p;
    int idx;
    logic [7:0] hb;
    p.act = (h < ha) && (v < VA);
    p.hs  = !((h >= ha + HFP) && (h < ha + HFP + HSY));
    p.vs  = !((v >= VA + VFP) && (v < VA + VFP + VSY));
    p.fs  = (h == 0) && (v == 0);
    p.x   = p.act ? 12'(h) : 12'd0;
    p.y   = p.act ? 12'(v) : 12'd0;
    p.rgb = 24'h0;
    hb    = 8'(h);
    if (p.act) begin
      case (pat)
        2'b00: begin
          idx = h / (ha / 8);
          if (idx > 7) idx = 7;
          p.rgb = bar_rgb(idx);
        end
        2'b01: p.rgb = solid;
        2'b10: p.rgb = {hb, hb, hb};
        default: p.rgb = (((h / 8) % 2) != ((v / 8) % 2)) ? 24'hFFFFFF : 24'h0;
      endcase
    end
    return p;
  endfunction

  // Model state for each instance: the raster position of the next pixel to
  // be emitted, the pattern latched for the current frame, and the expected
  // registered outputs.
  int          m_ha  [2] = '{HA0, HA1};
  int          m_pos [2];
  logic [1:0]  m_pat [2];
  logic [23:0] m_sol [2];
  px_t         m_exp [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int ht, h, v;
      ht = m_ha[d] + HFP + HSY + HBP;
      if (rst) begin
        m_pos[d] = 0;
        m_pat[d] = 2'b00;
        m_sol[d] = 24'h0;
        m_exp[d] = reset_px();
      end else if (ce) begin
        h = m_pos[d] % ht;
        v = m_pos[d] / ht;
        if (h == 0 && v == 0) begin
          m_pat[d] = pattern_sel;
          m_sol[d] = solid_rgb;
        end
        m_exp[d] = model_px(m_ha[d], h, v, m_pat[d], m_sol[d]);
        m_pos[d] = (m_pos[d] + 1) % (ht * VT);
      end
    end
  end

  // Inputs change only at negedge, and outputs are sampled at negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] pat, input logic [23:0] solid);
    rst = 1'b1; ce = 1'b1; pattern_sel = pat; solid_rgb = solid;
    step();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table (dut, H_TOTAL 24)
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [1:0]  pat;
    logic [23:0] solid;
    int          h;
    int          v;
    logic        hs;
    logic        vs;
    logic        act;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    px_t e;
    int n_fs, n_act, n_hs, n_vs, fs_a, fs_b, vs_first;

    rst = 1'b1; ce = 1'b1; pattern_sel = 2'b00; solid_rgb = 24'h0;
    step();
    check("reset_state", got0, reset_px());
    check("reset_state_w18", got1, reset_px());

    vecs.push_back('{"origin",       2'b00, 24'h0, 0,  0, 1'b1, 1'b1, 1'b1, 24'hFFFFFF});
    vecs.push_back('{"bar0_x1",      2'b00, 24'h0, 1,  0, 1'b1, 1'b1, 1'b1, 24'hFFFFFF});
    vecs.push_back('{"bar1_x2",      2'b00, 24'h0, 2,  1, 1'b1, 1'b1, 1'b1, 24'hFFFF00});
    vecs.push_back('{"bar2_x5",      2'b00, 24'h0, 5,  2, 1'b1, 1'b1, 1'b1, 24'h00FFFF});
    vecs.push_back('{"bar3_x7",      2'b00, 24'h0, 7,  1, 1'b1, 1'b1, 1'b1, 24'h00FF00});
    vecs.push_back('{"bar4_x9",      2'b00, 24'h0, 9,  0, 1'b1, 1'b1, 1'b1, 24'hFF00FF});
    vecs.push_back('{"bar5_x10",     2'b00, 24'h0, 10, 3, 1'b1, 1'b1, 1'b1, 24'hFF0000});
    vecs.push_back('{"bar6_x13",     2'b00, 24'h0, 13, 0, 1'b1, 1'b1, 1'b1, 24'h0000FF});
    vecs.push_back('{"bar7_x15",     2'b00, 24'h0, 15, 3, 1'b1, 1'b1, 1'b1, 24'h000000});
    vecs.push_back('{"hblank_x16",   2'b00, 24'h0, 16, 0, 1'b1, 1'b1, 1'b0, 24'h000000});
    vecs.push_back('{"hs_pre_x17",   2'b00, 24'h0, 17, 0, 1'b1, 1'b1, 1'b0, 24'h000000});
    vecs.push_back('{"hs_on_x18",    2'b00, 24'h0, 18, 0, 1'b0, 1'b1, 1'b0, 24'h000000});
    vecs.push_back('{"hs_on_x20",    2'b00, 24'h0, 20, 2, 1'b0, 1'b1, 1'b0, 24'h000000});
    vecs.push_back('{"hs_off_x21",   2'b00, 24'h0, 21, 0, 1'b1, 1'b1, 1'b0, 24'h000000});
    vecs.push_back('{"vblank_y4",    2'b00, 24'h0, 0,  4, 1'b1, 1'b1, 1'b0, 24'h000000});
    vecs.push_back('{"vs_on_y5",     2'b00, 24'h0, 0,  5, 1'b1, 1'b0, 1'b0, 24'h000000});
    vecs.push_back('{"vs_hs_y5",     2'b00, 24'h0, 19, 5, 1'b0, 1'b0, 1'b0, 24'h000000});
    vecs.push_back('{"vs_end_y5",    2'b00, 24'h0, 23, 5, 1'b1, 1'b0, 1'b0, 24'h000000});
    vecs.push_back('{"vs_off_y6",    2'b00, 24'h0, 0,  6, 1'b1, 1'b1, 1'b0, 24'h000000});
    vecs.push_back('{"hs_vblank_y7", 2'b00, 24'h0, 18, 7, 1'b0, 1'b1, 1'b0, 24'h000000});
    vecs.push_back('{"solid_x3",     2'b01, 24'h123456, 3, 1, 1'b1, 1'b1, 1'b1, 24'h123456});
    vecs.push_back('{"grey_x7",      2'b10, 24'h0, 7,  2, 1'b1, 1'b1, 1'b1, 24'h070707});
    vecs.push_back('{"grey_x15",     2'b10, 24'h0, 15, 3, 1'b1, 1'b1, 1'b1, 24'h0F0F0F});
    vecs.push_back('{"check_x8y0",   2'b11, 24'h0, 8,  0, 1'b1, 1'b1, 1'b1, 24'hFFFFFF});
    vecs.push_back('{"check_x3y3",   2'b11, 24'h0, 3,  3, 1'b1, 1'b1, 1'b1, 24'h000000});

    foreach (vecs[i]) begin
      do_reset(vecs[i].pat, vecs[i].solid);
      repeat (vecs[i].v * HT0 + vecs[i].h + 1) step();
      e = mk(vecs[i].hs, vecs[i].vs, vecs[i].act,
             (vecs[i].h == 0) && (vecs[i].v == 0), vecs[i].rgb,
             vecs[i].act ? vecs[i].h : 0, vecs[i].act ? vecs[i].v : 0);
      check(vecs[i].name, got0, e);
    end

    // Frame statistics over two full frames with ce held high.
    do_reset(2'b00, 24'h0);
    n_fs = 0; n_act = 0; n_hs = 0; n_vs = 0; fs_a = -1; fs_b = -1; vs_first = -1;
    for (int k = 1; k <= 2 * HT0 * VT; k++) begin
      step();
      if (fs0) begin
        n_fs++;
        if (fs_a < 0) fs_a = k; else if (fs_b < 0) fs_b = k;
      end
      if (act0) n_act++;
      if (!hs0) n_hs++;
      if (!vs0) begin
        n_vs++;
        if (vs_first < 0) vs_first = k;
      end
    end
    check_int("frame_start_count", n_fs, 2);
    check_int("frame_start_first", fs_a, 1);
    check_int("frame_start_period", fs_b - fs_a, HT0 * VT);
    check_int("active_count", n_act, 2 * HA0 * VA);
    check_int("hsync_low_count", n_hs, 2 * HSY * VT);
    check_int("vsync_low_count", n_vs, 2 * HT0);
    check_int("vsync_first_low", vs_first, 5 * HT0 + 1);

    // A mid-frame pattern change takes effect only at the next frame.
    do_reset(2'b00, 24'h0);
    repeat (49) step();                       // showing (0,2)
    pattern_sel = 2'b01; solid_rgb = 24'h123456;
    repeat (3) step();                        // showing (3,2)
    check("midframe_keep_bars", got0, mk(1, 1, 1, 0, 24'hFFFF00, 3, 2));
    repeat (30) step();                       // showing (9,3)
    check("midframe_keep_bars_y3", got0, mk(1, 1, 1, 0, 24'hFF00FF, 9, 3));
    repeat (111) step();                      // showing (0,0) of frame 2
    check("next_frame_solid", got0, mk(1, 1, 1, 1, 24'h123456, 0, 0));
    step();
    check("next_frame_solid_x1", got0, mk(1, 1, 1, 0, 24'h123456, 1, 0));

    // ce low for 5 cycles at x=7: outputs freeze, the frame stays 192 enabled cycles.
    do_reset(2'b00, 24'h0);
    repeat (8) step();
    e = mk(1, 1, 1, 0, 24'h00FF00, 7, 0);
    check("pre_stall_x7", got0, e);
    ce = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("ce_stall_hold", got0, e);
    end
    ce = 1'b1;
    step();
    check("post_stall_x8", got0, mk(1, 1, 1, 0, 24'hFF00FF, 8, 0));
    repeat (HT0 * VT - 9) step();
    check("stall_frame_end", got0, mk(1, 1, 0, 0, 24'h0, 0, 0));
    step();
    check("stall_frame_start", got0, mk(1, 1, 1, 1, 24'hFFFFFF, 0, 0));

    // frame_start holds while ce is low.
    do_reset(2'b00, 24'h0);
    step();
    ce = 1'b0;
    repeat (3) step();
    check_int("frame_start_hold", int'(fs0), 1);
    ce = 1'b1;

    // Reset mid-frame at (9,3), then the checkerboard from a clean frame.
    do_reset(2'b00, 24'h0);
    repeat (3 * HT0 + 10) step();
    check("pre_reset_x9y3", got0, mk(1, 1, 1, 0, 24'hFF00FF, 9, 3));
    rst = 1'b1; pattern_sel = 2'b11;
    step();
    check("midframe_reset", got0, reset_px());
    rst = 1'b0;
    step();
    check("restart_origin", got0, mk(1, 1, 1, 1, 24'h0, 0, 0));
    for (int k = 1; k < 8; k++) begin
      step();
      check("check_dark", got0, mk(1, 1, 1, 0, 24'h0, k, 0));
    end
    step();
    check("check_light_x8", got0, mk(1, 1, 1, 0, 24'hFFFFFF, 8, 0));

    // H_ACTIVE=18: bar 7 absorbs x=14..17, and blanking starts at x=18.
    do_reset(2'b00, 24'h0);
    repeat (13) step();
    check("w18_bar6_x12", got1, mk(1, 1, 1, 0, 24'h0000FF, 12, 0));
    step();
    check("w18_bar6_x13", got1, mk(1, 1, 1, 0, 24'h0000FF, 13, 0));
    for (int k = 14; k < 18; k++) begin
      step();
      check("w18_bar7", got1, mk(1, 1, 1, 0, 24'h000000, k, 0));
    end
    step();
    check("w18_blank_x18", got1, mk(1, 1, 0, 0, 24'h0, 0, 0));

    // Randomised run of both instances against the model.
    for (int k = 0; k < 4000; k++) begin
      ce  = ($urandom_range(0, 9) < 8);
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 39) == 0) pattern_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) solid_rgb   = 24'($urandom);
      step();
      check("random_dut", got0, m_exp[0]);
      check("random_w18", got1, m_exp[1]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
